// File: rtl/program_loader.sv
// program_loader: writer side of the 32 x 13-bit program memory.
// Accepts a framed byte stream (header N, then N {hi, lo} byte pairs),
// packs each pair into a {5-bit opcode, 8-bit operand} word and writes
// it with a single-cycle strobe. The core is held off the instruction
// bus while a load is running.
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, a trailing
// checksum byte (8-bit sum of header and data bytes) must match or the
// load ends in ERR. When undefined there is no checksum byte and no sum
// register.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int INS_W  = 13,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INS_W-1:0]  mem_data,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   loaded_count
);

  localparam int OPC_W = INS_W - 8;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, HDR, HI, LO, WR, CHK, DONE, ERR
  } loaderState_e;
`else
  typedef enum logic [2:0] {
    IDLE, HDR, HI, LO, WR, DONE, ERR
  } loaderState_e;
`endif

  loaderState_e        state_q;
  logic [ADDR_W:0]     wordCount_q;
  logic [ADDR_W:0]     loadCount_q;
  logic [OPC_W-1:0]    opcode_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [INS_W-1:0]    memData_q;
  logic                memWe_q;
  logic                cpuHold_q;
  logic                done_q;
  logic                err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q;
`endif

  logic                accept_d;
  logic [ADDR_W:0]     countInc_d;
  logic                headerBad_d;
  logic                hiBad_d;
  logic                lastWord_d;
  logic                canStart_d;

  // Ready is a pure function of state so the source sees it in the same cycle.
  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      HDR, HI, LO: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:         byte_ready = 1'b1;
`endif
      default:     byte_ready = 1'b0;
    endcase
  end

  // Handshake and frame-decode helpers shared by the state machine.
  always_comb begin
    accept_d    = byte_valid && byte_ready;
    countInc_d  = loadCount_q + CNT_ONE;
    headerBad_d = (byte_in == 8'd0) || (int'(byte_in) > DEPTH);
    hiBad_d     = |byte_in[7:OPC_W];
    lastWord_d  = (countInc_d == wordCount_q);
    canStart_d  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  end

  // Loader state machine with all outputs registered; reset wins over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wordCount_q <= '0;
      loadCount_q <= '0;
      opcode_q    <= '0;
      memAddr_q   <= '0;
      memData_q   <= '0;
      memWe_q     <= 1'b0;
      cpuHold_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      memWe_q <= 1'b0;
      if (canStart_d) begin
        state_q     <= HDR;
        done_q      <= 1'b0;
        err_q       <= 1'b0;
        loadCount_q <= '0;
        cpuHold_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum_q       <= '0;
`endif
      end else begin
        case (state_q)
          HDR: begin
            if (accept_d) begin
`ifdef LOADER_CHECKSUM_EN
              sum_q <= sum_q + byte_in;
`endif
              if (headerBad_d) begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end else begin
                wordCount_q <= (ADDR_W+1)'(byte_in);
                state_q     <= HI;
              end
            end
          end
          HI: begin
            if (accept_d) begin
`ifdef LOADER_CHECKSUM_EN
              sum_q <= sum_q + byte_in;
`endif
              if (hiBad_d) begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end else begin
                opcode_q <= byte_in[OPC_W-1:0];
                state_q  <= LO;
              end
            end
          end
          LO: begin
            if (accept_d) begin
`ifdef LOADER_CHECKSUM_EN
              sum_q <= sum_q + byte_in;
`endif
              memAddr_q <= loadCount_q[ADDR_W-1:0];
              memData_q <= INS_W'({opcode_q, byte_in});
              memWe_q   <= 1'b1;
              state_q   <= WR;
            end
          end
          WR: begin
            loadCount_q <= countInc_d;
            if (lastWord_d) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= CHK;
`else
              state_q   <= DONE;
              done_q    <= 1'b1;
              cpuHold_q <= 1'b0;
`endif
            end else begin
              state_q <= HI;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHK: begin
            if (accept_d) begin
              if (byte_in == sum_q) begin
                state_q   <= DONE;
                done_q    <= 1'b1;
                cpuHold_q <= 1'b0;
              end else begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end
            end
          end
`endif
          IDLE, DONE, ERR: begin
            state_q <= state_q;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign mem_addr     = memAddr_q;
  assign mem_data     = memData_q;
  assign mem_we       = memWe_q;
  assign cpu_hold     = cpuHold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign loaded_count = loadCount_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. Follows LOADER_CHECKSUM_EN so the
// same stream sequence works with or without the trailing checksum byte.
module tb_program_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [4:0]  mem_addr;
  logic [12:0] mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [5:0]  loaded_count;

  typedef struct {
    logic [4:0]  addr;
    logic [12:0] data;
    int          cycle;
  } wrEntry_t;

  wrEntry_t writeLog[$];
  int       cycleCount = 0;
  int       errors = 0;
  int       checks = 0;
  logic [7:0] tbSum;

  program_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .loaded_count (loaded_count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe mid-cycle, tagged with a cycle stamp.
  always @(negedge clk) begin
    cycleCount <= cycleCount + 1;
    if (mem_we === 1'b1) writeLog.push_back('{mem_addr, mem_data, cycleCount});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offer one byte and hold it until the loader takes it (bounded).
  task automatic applyStimulus(input logic [7:0] b);
    bit got = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) got = 1;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    tbSum = tbSum + b;
    checkOutput("byteAccepted", {31'd0, got}, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic beginLoad();
    writeLog.delete();
    tbSum = 8'd0;
    pulseStart();
  endtask

  task automatic sendChecksum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(c);
`else
    if (c == 8'hFF) $display("[TB] note: checksum byte not used in this build");
`endif
  endtask

  // Bounded wait for done or err.
  task automatic waitFlag();
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) seen = 1;
    end
    checkOutput("flagTimeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".byte_ready"}, {31'd0, byte_ready}, 32'd0);
    checkOutput({tag, ".mem_addr"}, {27'd0, mem_addr}, 32'd0);
    checkOutput({tag, ".mem_data"}, {19'd0, mem_data}, 32'd0);
    checkOutput({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
    checkOutput({tag, ".cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, ".loaded_count"}, {26'd0, loaded_count}, 32'd0);
  endtask

  // Directed sequence of load scenarios.
  initial begin
    logic [7:0] hiB;
    logic [7:0] loB;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    tbSum      = 8'd0;

    // Reset values, with start held during reset (reset wins).
    start = 1'b1;
    idleCycles(2);
    checkResetValues("reset");
    start = 1'b0;
    rst_n = 1'b1;
    idleCycles(1);
    checkOutput("idle.cpu_hold", {31'd0, cpu_hold}, 32'd0);

    // Single word 0x0521 (checksum 0x27).
    beginLoad();
    checkOutput("t1.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("t1.byte_ready", {31'd0, byte_ready}, 32'd1);
    applyStimulus(8'h01);
    applyStimulus(8'h05);
    applyStimulus(8'h21);
    sendChecksum(8'h27);
    waitFlag();
    checkOutput("t1.writes", writeLog.size(), 32'd1);
    if (writeLog.size() >= 1) begin
      checkOutput("t1.addr", {27'd0, writeLog[0].addr}, 32'd0);
      checkOutput("t1.data", {19'd0, writeLog[0].data}, 32'h0521);
    end
    checkOutput("t1.done", {31'd0, done}, 32'd1);
    checkOutput("t1.err", {31'd0, err}, 32'd0);
    checkOutput("t1.cpu_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("t1.loaded_count", {26'd0, loaded_count}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Same word, wrong checksum: write still happens, then ERR.
    beginLoad();
    applyStimulus(8'h01);
    applyStimulus(8'h05);
    applyStimulus(8'h21);
    applyStimulus(8'h28);
    waitFlag();
    checkOutput("t1b.writes", writeLog.size(), 32'd1);
    checkOutput("t1b.err", {31'd0, err}, 32'd1);
    checkOutput("t1b.done", {31'd0, done}, 32'd0);
    checkOutput("t1b.cpu_hold", {31'd0, cpu_hold}, 32'd1);
`endif

    // Full 32-word frame, continuous valid.
    beginLoad();
    checkOutput("t2.countCleared", {26'd0, loaded_count}, 32'd0);
    checkOutput("t2.doneCleared", {31'd0, done}, 32'd0);
    applyStimulus(8'd32);
    for (int i = 0; i < 32; i++) begin
      hiB = 8'(i);
      loB = 8'(i * 7 + 1);
      applyStimulus(hiB);
      applyStimulus(loB);
    end
    sendChecksum(tbSum);
    waitFlag();
    checkOutput("t2.writes", writeLog.size(), 32'd32);
    for (int i = 0; i < 32 && i < writeLog.size(); i++) begin
      checkOutput($sformatf("t2.addr%0d", i), {27'd0, writeLog[i].addr}, 32'(i));
      checkOutput($sformatf("t2.data%0d", i), {19'd0, writeLog[i].data},
                  32'((i << 8) | ((i * 7 + 1) & 255)));
      if (i > 0)
        checkOutput($sformatf("t2.gap%0d", i), 32'(writeLog[i].cycle - writeLog[i-1].cycle), 32'd3);
    end
    checkOutput("t2.done", {31'd0, done}, 32'd1);
    checkOutput("t2.loaded_count", {26'd0, loaded_count}, 32'd32);

    // Header 0 and header 33 are framing errors.
    beginLoad();
    applyStimulus(8'h00);
    waitFlag();
    checkOutput("t3a.err", {31'd0, err}, 32'd1);
    checkOutput("t3a.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("t3a.writes", writeLog.size(), 32'd0);
    beginLoad();
    checkOutput("t3b.errCleared", {31'd0, err}, 32'd0);
    applyStimulus(8'h21);
    waitFlag();
    checkOutput("t3b.err", {31'd0, err}, 32'd1);
    checkOutput("t3b.done", {31'd0, done}, 32'd0);
    checkOutput("t3b.cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("t3b.writes", writeLog.size(), 32'd0);
    checkOutput("t3b.byte_ready", {31'd0, byte_ready}, 32'd0);

    // Bad hi byte 0x25 on the second word: only word 0 written.
    beginLoad();
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    applyStimulus(8'h10);
    applyStimulus(8'h25);
    waitFlag();
    checkOutput("t4.writes", writeLog.size(), 32'd1);
    if (writeLog.size() >= 1)
      checkOutput("t4.data", {19'd0, writeLog[0].data}, 32'h0110);
    checkOutput("t4.err", {31'd0, err}, 32'd1);
    checkOutput("t4.loaded_count", {26'd0, loaded_count}, 32'd1);

    // Gaps in valid plus a start pulse mid-load; checksum 0x36.
    beginLoad();
    applyStimulus(8'h03);
    idleCycles(2);
    applyStimulus(8'h1F);
    pulseStart();
    applyStimulus(8'hAA);
    idleCycles(3);
    applyStimulus(8'h00);
    pulseStart();
    applyStimulus(8'h55);
    applyStimulus(8'h0A);
    idleCycles(1);
    applyStimulus(8'h0B);
    checkOutput("t5.sumModel", {24'd0, tbSum}, 32'h36);
    sendChecksum(8'h36);
    waitFlag();
    checkOutput("t5.writes", writeLog.size(), 32'd3);
    if (writeLog.size() >= 3) begin
      checkOutput("t5.data0", {19'd0, writeLog[0].data}, 32'h1FAA);
      checkOutput("t5.data1", {19'd0, writeLog[1].data}, 32'h0055);
      checkOutput("t5.data2", {19'd0, writeLog[2].data}, 32'h0A0B);
      checkOutput("t5.addr2", {27'd0, writeLog[2].addr}, 32'd2);
    end
    checkOutput("t5.done", {31'd0, done}, 32'd1);
    checkOutput("t5.loaded_count", {26'd0, loaded_count}, 32'd3);

    // Reset after the second word, then a fresh load.
    beginLoad();
    applyStimulus(8'h04);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h04);
    idleCycles(1);
    checkOutput("t6.countBefore", {26'd0, loaded_count}, 32'd2);
    rst_n = 1'b0;
    idleCycles(1);
    checkResetValues("t6.reset");
    checkOutput("t6.writes", writeLog.size(), 32'd2);
    rst_n = 1'b1;
    beginLoad();
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    sendChecksum(tbSum);
    waitFlag();
    checkOutput("t6.reload.writes", writeLog.size(), 32'd1);
    if (writeLog.size() >= 1)
      checkOutput("t6.reload.data", {19'd0, writeLog[0].data}, 32'h1234);
    checkOutput("t6.reload.done", {31'd0, done}, 32'd1);
    checkOutput("t6.reload.count", {26'd0, loaded_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
